// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the register file.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  // $zero: architecturally hardwired to zero.
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports and one write port that commits on the
// falling edge of clk, so writeback data produced in the first half of a
// cycle is readable in the second half of that cycle. Register 0 always
// reads as zero. The control-unit flags ride along on the interface but do
// not influence the storage.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic [DATA_WIDTH-1:0] writeBack,
  input  logic                  RegisterWrite,
  input  logic                  MemoryToRegister,
  input  logic                  MemoryWrite,
  input  logic                  Branch,
  input  logic                  ALUSrc
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_en_d;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;

  // Control flags are part of the datapath bundle but carry no meaning here.
  logic unused_ctrl;
  assign unused_ctrl = ^{MemoryToRegister, MemoryWrite, Branch, ALUSrc};

  // Qualify the write: enabled and not targeting the hardwired zero register.
  always_comb begin
    wr_en_d = 1'b0;
    if (RegisterWrite && (writeRegister != ZERO_ADDR)) begin
      wr_en_d = 1'b1;
    end
  end

  // Storage: cleared asynchronously by reset, written on the falling clock edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[writeRegister] <= writeBack;
    end
  end

  // Read port 1: combinational lookup, address 0 forced to zero.
  always_comb begin
    rd1_d = regs_q[readRegister1];
    if (readRegister1 == ZERO_ADDR) begin
      rd1_d = '0;
    end
  end

  // Read port 2: combinational lookup, address 0 forced to zero.
  always_comb begin
    rd2_d = regs_q[readRegister2];
    if (readRegister2 == ZERO_ADDR) begin
      rd2_d = '0;
    end
  end

  assign readData1 = rd1_d;
  assign readData2 = rd2_d;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] writeBack;
  logic        RegisterWrite;
  logic        MemoryToRegister;
  logic        MemoryWrite;
  logic        Branch;
  logic        ALUSrc;

  int pass_cnt;
  int total_cnt;

  register_file dut (
    .clk              (clk),
    .rst              (rst),
    .readRegister1    (readRegister1),
    .readRegister2    (readRegister2),
    .writeRegister    (writeRegister),
    .readData1        (readData1),
    .readData2        (readData2),
    .writeBack        (writeBack),
    .RegisterWrite    (RegisterWrite),
    .MemoryToRegister (MemoryToRegister),
    .MemoryWrite      (MemoryWrite),
    .Branch           (Branch),
    .ALUSrc           (ALUSrc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Present a write in the high phase; it commits on the next falling edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    RegisterWrite = 1'b1;
    writeRegister = a;
    writeBack     = d;
    @(negedge clk);
    #1;
    RegisterWrite = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    readRegister1 = 5'd5;
    readRegister2 = 5'd31;
    #1;
    total_cnt++;
    if (readData1 !== 32'h0) $display("FAIL reset_rd1_low: got %h expected %h", readData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL reset_rd2_low: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
    // A write attempted while reset is held must be blocked.
    RegisterWrite = 1'b1;
    writeRegister = 5'd5;
    writeBack     = 32'h0000_0077;
    @(negedge clk);
    #1;
    RegisterWrite = 1'b0;
    total_cnt++;
    if (readData1 !== 32'h0) $display("FAIL reset_blocks_write: got %h expected %h", readData1, 32'h0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (readData1 !== 32'h0) $display("FAIL reset_rd1_after: got %h expected %h", readData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL reset_rd2_after: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_basic_write;
    do_write(5'd1, 32'hFFFF_FFFF);
    readRegister1 = 5'd1;
    #1;
    total_cnt++;
    if (readData1 !== 32'hFFFF_FFFF) $display("FAIL basic_write: got %h expected %h", readData1, 32'hFFFF_FFFF);
    else pass_cnt++;
  endtask

  task automatic test_write_disabled;
    @(posedge clk);
    #1;
    RegisterWrite = 1'b0;
    writeRegister = 5'd2;
    writeBack     = 32'h1234_5678;
    @(negedge clk);
    #1;
    readRegister2 = 5'd2;
    #1;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL write_disabled: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_reg_zero;
    do_write(5'd0, 32'hDEAD_BEEF);
    readRegister1 = 5'd0;
    readRegister2 = 5'd0;
    #1;
    total_cnt++;
    if (readData1 !== 32'h0) $display("FAIL reg0_rd1: got %h expected %h", readData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL reg0_rd2: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_dual_read;
    do_write(5'd3, 32'hA5A5_A5A5);
    do_write(5'd4, 32'h5A5A_5A5A);
    readRegister1 = 5'd3;
    readRegister2 = 5'd4;
    #1;
    total_cnt++;
    if (readData1 !== 32'hA5A5_A5A5) $display("FAIL dual_rd1: got %h expected %h", readData1, 32'hA5A5_A5A5);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h5A5A_5A5A) $display("FAIL dual_rd2: got %h expected %h", readData2, 32'h5A5A_5A5A);
    else pass_cnt++;
    readRegister2 = 5'd3;
    #1;
    total_cnt++;
    if (readData2 !== 32'hA5A5_A5A5) $display("FAIL same_addr_rd2: got %h expected %h", readData2, 32'hA5A5_A5A5);
    else pass_cnt++;
  endtask

  task automatic test_read_during_write;
    readRegister1 = 5'd3;
    @(posedge clk);
    #1;
    RegisterWrite = 1'b1;
    writeRegister = 5'd3;
    writeBack     = 32'h0000_0001;
    #1;
    total_cnt++;
    if (readData1 !== 32'hA5A5_A5A5) $display("FAIL rw_old_value: got %h expected %h", readData1, 32'hA5A5_A5A5);
    else pass_cnt++;
    @(negedge clk);
    #1;
    RegisterWrite = 1'b0;
    total_cnt++;
    if (readData1 !== 32'h0000_0001) $display("FAIL rw_new_value: got %h expected %h", readData1, 32'h0000_0001);
    else pass_cnt++;
  endtask

  task automatic test_edge_sampling;
    @(posedge clk);
    #1;
    RegisterWrite = 1'b1;
    writeRegister = 5'd6;
    writeBack     = 32'h1111_1111;
    @(negedge clk);
    #1;
    // Change data/address in the low phase while enable is still high.
    writeBack     = 32'h2222_2222;
    writeRegister = 5'd7;
    readRegister1 = 5'd6;
    readRegister2 = 5'd7;
    #1;
    total_cnt++;
    if (readData1 !== 32'h1111_1111) $display("FAIL sample_mid_rd6: got %h expected %h", readData1, 32'h1111_1111);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL sample_mid_rd7: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    RegisterWrite = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (readData1 !== 32'h1111_1111) $display("FAIL sample_after_rd6: got %h expected %h", readData1, 32'h1111_1111);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL sample_after_rd7: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_ctrl_flags;
    readRegister1 = 5'd1;
    readRegister2 = 5'd3;
    @(posedge clk);
    #1;
    MemoryToRegister = 1'b1;
    MemoryWrite      = 1'b1;
    Branch           = 1'b1;
    ALUSrc           = 1'b1;
    writeRegister    = 5'd1;
    writeBack        = 32'h0BAD_0BAD;
    @(negedge clk);
    #1;
    total_cnt++;
    if (readData1 !== 32'hFFFF_FFFF) $display("FAIL flags_no_write_rd1: got %h expected %h", readData1, 32'hFFFF_FFFF);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0000_0001) $display("FAIL flags_no_write_rd2: got %h expected %h", readData2, 32'h0000_0001);
    else pass_cnt++;
    do_write(5'd8, 32'hCAFE_F00D);
    readRegister1 = 5'd8;
    #1;
    total_cnt++;
    if (readData1 !== 32'hCAFE_F00D) $display("FAIL flags_write_ok: got %h expected %h", readData1, 32'hCAFE_F00D);
    else pass_cnt++;
    MemoryToRegister = 1'b0;
    MemoryWrite      = 1'b0;
    Branch           = 1'b0;
    ALUSrc           = 1'b0;
  endtask

  task automatic test_async_reset;
    readRegister1 = 5'd1;
    readRegister2 = 5'd3;
    @(posedge clk);
    #2;
    // Pending write to reg 9, then reset lands before the falling edge.
    RegisterWrite = 1'b1;
    writeRegister = 5'd9;
    writeBack     = 32'h0000_ABCD;
    rst           = 1'b0;
    #1;
    total_cnt++;
    if (readData1 !== 32'h0) $display("FAIL async_rst_rd1: got %h expected %h", readData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL async_rst_rd2: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
    Branch = 1'b1;
    ALUSrc = 1'b1;
    @(negedge clk);
    #1;
    RegisterWrite = 1'b0;
    Branch        = 1'b0;
    ALUSrc        = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    readRegister1 = 5'd9;
    readRegister2 = 5'd8;
    #1;
    total_cnt++;
    if (readData1 !== 32'h0) $display("FAIL rst_wins_pending: got %h expected %h", readData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData2 !== 32'h0) $display("FAIL rst_cleared_r8: got %h expected %h", readData2, 32'h0);
    else pass_cnt++;
    do_write(5'd10, 32'h0000_0012);
    readRegister1 = 5'd10;
    #1;
    total_cnt++;
    if (readData1 !== 32'h0000_0012) $display("FAIL write_after_rst: got %h expected %h", readData1, 32'h0000_0012);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt         = 0;
    total_cnt        = 0;
    rst              = 1'b1;
    readRegister1    = 5'd0;
    readRegister2    = 5'd0;
    writeRegister    = 5'd0;
    writeBack        = 32'h0;
    RegisterWrite    = 1'b0;
    MemoryToRegister = 1'b0;
    MemoryWrite      = 1'b0;
    Branch           = 1'b0;
    ALUSrc           = 1'b0;
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_reg_zero();
    test_dual_read();
    test_read_during_write();
    test_edge_sampling();
    test_ctrl_flags();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Two asynchronous (combinational) read ports and one write port.
- Sits between instruction decode (register specifiers) and the ALU/writeback mux; writeback data arrives from the MemoryToRegister mux.
- Datapath control flags from the control unit are carried on the interface but have no effect on register-file state.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register specifier width; depth = 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  system clock; the write commits on the falling edge.
- rst  input  1  asynchronous, active-low reset; clears all registers.
- readRegister1  input  5  read port 1 address.
- readRegister2  input  5  read port 2 address.
- writeRegister  input  5  write port address.
- readData1  output  32  contents of readRegister1, combinational.
- readData2  output  32  contents of readRegister2, combinational.
- writeBack  input  32  write data.
- RegisterWrite  input  1  write enable, active high.
- MemoryToRegister  input  1  control flag; no effect on this block.
- MemoryWrite  input  1  control flag; no effect on this block.
- Branch  input  1  control flag; no effect on this block.
- ALUSrc  input  1  control flag; no effect on this block.

Behaviour:
- Storage is 32 x 32-bit registers, indexed 0..31.
- Reset: rst low clears all 32 registers to 32'h0 immediately, independent of clk.
  - While rst is low, writes are blocked.
  - readData1 and readData2 read 0 during reset and after release, until a write occurs.
  - Reset asserted during a pending write: reset wins and the register stays 0.
- Write:
  - On each falling edge of clk with rst high, RegisterWrite=1 and writeRegister != 0, reg[writeRegister] <= writeBack.
  - RegisterWrite=0: no state change.
  - Writes are sampled only at the falling edge; changes to writeBack, writeRegister or RegisterWrite between edges have no effect.
- Register 0: hardwired zero. Writes to address 0 are ignored; reads of address 0 return 32'h0.
- Read:
  - readDataN = reg[readRegisterN], purely combinational, zero-cycle latency.
  - The outputs reflect a newly written value immediately after the falling edge that commits it, so a value written in the first half of a cycle is visible within the same cycle.
- Simultaneous events:
  - Both read ports may address the same register.
  - A read and a write to the same address return the old value before the falling edge and the new value after it.
  - There is no explicit bypass path.
- X handling: an unknown read address yields unknown read data. There is no other error signalling.
- MemoryToRegister, MemoryWrite, Branch and ALUSrc are accepted and ignored. They do not gate writes or reads.

Decomposition:
- Shared package (mips_pkg): DATA_WIDTH, ADDR_WIDTH, NUM_REGS=32, REG_ZERO=5'd0, and a reg_addr_t / word_t typedef.
- No sub-module is warranted. The file is one flat module containing the storage array, the write process (negedge clk / negedge rst) and two combinational read muxes.

Test Plan:
- Reset: drive rst=0, then rst=1; set readRegister1=5, readRegister2=31 -> readData1=0, readData2=0.
- Basic write/read: rst=1, RegisterWrite=1, writeRegister=1, writeBack=32'hFFFFFFFF, clk 1->0; then RegisterWrite=0, readRegister1=1 -> readData1=32'hFFFFFFFF (4294967295).
- Write disabled: RegisterWrite=0, writeRegister=2, writeBack=32'h12345678, falling edge; readRegister2=2 -> readData2=0.
- Register 0 protection: RegisterWrite=1, writeRegister=0, writeBack=32'hDEADBEEF, falling edge; readRegister1=0 -> readData1=0.
- Dual read / timing:
  - Write reg 3=32'hA5A5A5A5 and reg 4=32'h5A5A5A5A on successive falling edges; read 3 and 4 -> readData1=32'hA5A5A5A5, readData2=32'h5A5A5A5A.
  - Read reg 3 while writing 32'h1 to it -> readData1 is old value before the falling edge, 32'h1 after.
- Async reset mid-operation: after writes, pull rst low between edges -> all reads return 0 at once, without a clock edge; toggling control flags (Branch, ALUSrc, MemoryWrite, MemoryToRegister) changes nothing.
